// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller.
// FSM state and redirect-source encodings plus the sequential PC helper.
package fetch_pc_ctrl_pkg;

  localparam logic [31:0] PcResetDefault = 32'h1c00_0000;

  typedef enum logic [1:0] {
    FpcInit = 2'd0,
    FpcRun  = 2'd1,
    FpcHold = 2'd2
  } fpc_state_e;

  typedef enum logic [1:0] {
    RsrcNone  = 2'd0,
    RsrcFlush = 2'd1,
    RsrcPriv  = 2'd2,
    RsrcBp    = 2'd3
  } rsrc_e;

  // Fetch proceeds in aligned 8-byte pairs; a pc[2]=1 start fetches one instruction.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return {pc[31:3] + 29'd1, 3'b000};
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Bundle of redirect inputs, icache/IF1 handshake and fetch outputs.
// master = fetch PC controller, slave = surrounding frontend/backend.
interface fetch_pc_ctrl_if #(
  parameter int unsigned CntW = 32
) ();

  logic            flush;
  logic [31:0]     flush_pc;
  logic            set_pc_from_PRIV;
  logic [31:0]     pc_from_PRIV;
  logic            bp_redirect;
  logic [31:0]     bp_redirect_pc;
  logic            icache_rready;
  logic            if1_allowin;
  logic [31:0]     fetch_pc;
  logic [31:0]     fetch_pc_next;
  logic            fetch_valid;
  logic [1:0]      redirect_src;
  logic [CntW-1:0] perf_stall_cnt;
  logic [CntW-1:0] perf_redir_cnt;

  modport master (
    input  flush, flush_pc, set_pc_from_PRIV, pc_from_PRIV, bp_redirect, bp_redirect_pc,
    input  icache_rready, if1_allowin,
    output fetch_pc, fetch_pc_next, fetch_valid, redirect_src, perf_stall_cnt, perf_redir_cnt
  );

  modport slave (
    output flush, flush_pc, set_pc_from_PRIV, pc_from_PRIV, bp_redirect, bp_redirect_pc,
    output icache_rready, if1_allowin,
    input  fetch_pc, fetch_pc_next, fetch_valid, redirect_src, perf_stall_cnt, perf_redir_cnt
  );

endinterface

// File: rtl/fetch_redirect_mux.sv
// Combinational priority select of redirect target: flush > priv > bp.
// Callers gate the enables according to the controller state.
module fetch_redirect_mux
  import fetch_pc_ctrl_pkg::*;
(
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        priv_i,
  input  logic [31:0] priv_pc_i,
  input  logic        bp_i,
  input  logic [31:0] bp_pc_i,
  output logic [31:0] tgt_pc_o,
  output rsrc_e       src_o
);

  always_comb begin
    tgt_pc_o = bp_pc_i;
    src_o    = RsrcNone;
    if (flush_i) begin
      tgt_pc_o = flush_pc_i;
      src_o    = RsrcFlush;
    end else if (priv_i) begin
      tgt_pc_o = priv_pc_i;
      src_o    = RsrcPriv;
    end else if (bp_i) begin
      tgt_pc_o = bp_pc_i;
      src_o    = RsrcBp;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC owner: INIT/RUN/HOLD sequencing of IF0 requests and redirect arbitration.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = PcResetDefault,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_ctrl_if.master bus
);

  localparam int unsigned    InitW    = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] InitLoad = (INIT_CYCLES > 0) ? InitW'(INIT_CYCLES - 1) : '0;

  fpc_state_e       state_q, state_d;
  logic [InitW-1:0] cnt_q, cnt_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      priv_pc_q, priv_pc_d;
  rsrc_e            redirect_src_q, redirect_src_d;

  logic             fetch_valid;
  logic             fire;
  logic [31:0]      pc_next;
  logic             mux_priv;
  logic             mux_bp;
  logic [31:0]      mux_priv_pc;
  logic [31:0]      mux_pc;
  rsrc_e            mux_src;

  assign fetch_valid = (state_q == FpcRun);
  assign fire        = fetch_valid & bus.icache_rready & bus.if1_allowin;
  assign pc_next     = seq_next_pc(fetch_pc_q);

  // In RUN the priv input means "enter HOLD"; in HOLD it means "resume at the latched PC".
  assign mux_priv    = (state_q == FpcRun)  ? bus.set_pc_from_PRIV :
                       (state_q == FpcHold) ? ~bus.set_pc_from_PRIV : 1'b0;
  assign mux_priv_pc = (state_q == FpcHold) ? priv_pc_q : bus.pc_from_PRIV;
  assign mux_bp      = (state_q == FpcRun) & bus.bp_redirect;

  fetch_redirect_mux u_redirect_mux (
    .flush_i   (bus.flush),
    .flush_pc_i(bus.flush_pc),
    .priv_i    (mux_priv),
    .priv_pc_i (mux_priv_pc),
    .bp_i      (mux_bp),
    .bp_pc_i   (bus.bp_redirect_pc),
    .tgt_pc_o  (mux_pc),
    .src_o     (mux_src)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fetch_pc_d     = fetch_pc_q;
    priv_pc_d      = priv_pc_q;
    redirect_src_d = RsrcNone;
    case (state_q)
      FpcInit: begin
        if (cnt_q == '0) begin
          state_d = FpcRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (mux_src == RsrcFlush) begin
          fetch_pc_d     = mux_pc;
          redirect_src_d = RsrcFlush;
        end
      end
      FpcRun: begin
        unique case (mux_src)
          RsrcFlush, RsrcBp: begin
            fetch_pc_d     = mux_pc;
            redirect_src_d = mux_src;
          end
          RsrcPriv: begin
            // Any fire this cycle is dropped: the resume PC replaces it.
            priv_pc_d = mux_pc;
            state_d   = FpcHold;
          end
          RsrcNone: begin
            if (fire) fetch_pc_d = pc_next;
          end
        endcase
      end
      FpcHold: begin
        if (bus.set_pc_from_PRIV) priv_pc_d = bus.pc_from_PRIV;
        if (mux_src != RsrcNone) begin
          fetch_pc_d     = mux_pc;
          redirect_src_d = mux_src;
          state_d        = FpcRun;
        end
      end
      default: state_d = FpcInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FpcInit;
      cnt_q          <= InitLoad;
      fetch_pc_q     <= PC_RESET;
      priv_pc_q      <= PC_RESET;
      redirect_src_q <= RsrcNone;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fetch_pc_q     <= fetch_pc_d;
      priv_pc_q      <= priv_pc_d;
      redirect_src_q <= redirect_src_d;
    end
  end

  assign bus.fetch_pc      = fetch_pc_q;
  assign bus.fetch_pc_next = pc_next;
  assign bus.fetch_valid   = fetch_valid;
  assign bus.redirect_src  = redirect_src_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  // Both counters saturate at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (fetch_valid && !fire && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((redirect_src_q != RsrcNone) && (redir_cnt_q != '1)) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_redir_cnt = redir_cnt_q;
`else
  assign bus.perf_stall_cnt = CNT_W'(0);
  assign bus.perf_redir_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: a mode-based reference model queues the expected
// outputs of every cycle, and a negedge monitor pops and compares them.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] PcRst  = 32'h1c00_0000;
  localparam int          InitCy = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid;
    logic [1:0]  src;
    logic [31:0] stall;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.CntW(32)) bus ();

  fetch_pc_ctrl #(
    .PC_RESET   (PcRst),
    .INIT_CYCLES(InitCy),
    .CNT_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 = waiting for icache init, 1 = fetching, 2 = frozen by serializer.
  int          m_mode;
  int          m_init_left;
  logic [31:0] m_pc;
  logic [31:0] m_resume_pc;
  logic [1:0]  m_src;
  logic [31:0] m_stall;
  logic [31:0] m_redir;

  function automatic logic [31:0] pair_after(input logic [31:0] pc);
    logic [31:0] r;
    r = ((pc >> 3) + 32'd1) << 3;
    return r;
  endfunction

  task automatic model_reset();
    m_mode      = 0;
    m_init_left = InitCy;
    m_pc        = PcRst;
    m_resume_pc = PcRst;
    m_src       = 2'd0;
    m_stall     = 0;
    m_redir     = 0;
  endtask

  task automatic model_step(input logic f, input logic [31:0] fpc, input logic p,
                            input logic [31:0] ppc, input logic b, input logic [31:0] bpc,
                            input logic rr, input logic al);
    logic       valid;
    logic       fired;
    logic [1:0] nsrc;
    valid = (m_mode == 1);
    fired = valid && rr && al;
    if (valid && !fired && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (m_src != 0 && m_redir != 32'hFFFF_FFFF) m_redir++;
    nsrc = 2'd0;
    if (m_mode == 0) begin
      if (f) begin m_pc = fpc; nsrc = 2'd1; end
      m_init_left--;
      if (m_init_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (f) begin m_pc = fpc; nsrc = 2'd1; end
      else if (p) begin m_resume_pc = ppc; m_mode = 2; end
      else if (b) begin m_pc = bpc; nsrc = 2'd3; end
      else if (fired) m_pc = pair_after(m_pc);
    end else begin
      if (f) begin m_pc = fpc; nsrc = 2'd1; m_mode = 1; end
      else if (p) m_resume_pc = ppc;
      else begin m_pc = m_resume_pc; nsrc = 2'd2; m_mode = 1; end
    end
    m_src = nsrc;
  endtask

  task automatic push_expected();
    exp_t e;
    e.pc      = m_pc;
    e.pc_next = pair_after(m_pc);
    e.valid   = (m_mode == 1);
    e.src     = m_src;
`ifdef FETCH_PERF_CNT_EN
    e.stall   = m_stall;
    e.redir   = m_redir;
`else
    e.stall   = 32'd0;
    e.redir   = 32'd0;
`endif
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: expected outputs for this cycle are queued before inputs change.
  task automatic step(input logic r, input logic f, input logic [31:0] fpc, input logic p,
                      input logic [31:0] ppc, input logic b, input logic [31:0] bpc,
                      input logic rr, input logic al);
    @(posedge clk);
    #1;
    rst = r;
    if (r) model_reset();
    push_expected();
    bus.flush            = f;
    bus.flush_pc         = fpc;
    bus.set_pc_from_PRIV = p;
    bus.pc_from_PRIV     = ppc;
    bus.bp_redirect      = b;
    bus.bp_redirect_pc   = bpc;
    bus.icache_rready    = rr;
    bus.if1_allowin      = al;
    if (!r) model_step(f, fpc, p, ppc, b, bpc, rr, al);
  endtask

  task automatic run_idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, rr, 1'b1);
  endtask

  task automatic do_flush(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("fetch_pc", bus.fetch_pc, e.pc);
      chk("fetch_pc_next", bus.fetch_pc_next, e.pc_next);
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, e.valid});
      chk("redirect_src", {30'd0, bus.redirect_src}, {30'd0, e.src});
      chk("perf_stall_cnt", bus.perf_stall_cnt, e.stall);
      chk("perf_redir_cnt", bus.perf_redir_cnt, e.redir);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        lvl;
    logic [31:0] lvl_pc;
    model_reset();
    bus.flush            = 1'b0;
    bus.flush_pc         = '0;
    bus.set_pc_from_PRIV = 1'b0;
    bus.pc_from_PRIV     = '0;
    bus.bp_redirect      = 1'b0;
    bus.bp_redirect_pc   = '0;
    bus.icache_rready    = 1'b0;
    bus.if1_allowin      = 1'b0;

    // Reset and init window, then sequential pairs from the reset PC.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    run_idle(9, 1'b1);

    // Odd-word start and top-of-address wrap.
    do_flush(32'h1c00_0004);
    run_idle(2, 1'b1);
    do_flush(32'hFFFF_FFF8);
    run_idle(2, 1'b1);

    // Flush beats bp_redirect and fire in the same cycle.
    step(1'b0, 1'b1, 32'h1c00_0100, 1'b0, 32'd0, 1'b1, 32'h1c00_0200, 1'b1, 1'b1);
    run_idle(2, 1'b1);

    // Serializer freeze for 6 cycles, then resume at its PC.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 32'h1c00_0044, 1'b0, 32'd0, 1'b1, 1'b1);
    run_idle(3, 1'b1);

    // Flush while frozen wins over the latched resume PC; bp is ignored in HOLD.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 32'h1c00_0080, 1'b1, 32'h1c00_0400, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h1c00_0300, 1'b1, 32'h1c00_0080, 1'b0, 32'd0, 1'b1, 1'b1);
    run_idle(2, 1'b1);

    // icache back-pressure holds the PC and counts stalls.
    run_idle(3, 1'b0);
    run_idle(2, 1'b1);

    // Reset mid-run, then a flush during the init window.
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    do_flush(32'h1c00_0500);
    run_idle(5, 1'b1);

    // Randomized traffic with a level-style serializer signal.
    lvl    = 1'b0;
    lvl_pc = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      if (lvl) begin
        if ($urandom_range(4) == 0) lvl = 1'b0;
      end else if ($urandom_range(19) == 0) begin
        lvl = 1'b1;
      end
      if ($urandom_range(2) == 0) lvl_pc = $urandom;
      r = ($urandom_range(299) == 0);
      step(r, ($urandom_range(15) == 0), $urandom, lvl, lvl_pc, ($urandom_range(7) == 0),
           $urandom, ($urandom_range(3) != 0), ($urandom_range(3) != 0));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
